// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a synchronous FIFO: one word per frame, LSB first, idle-high line.
// Define UART_TX_PARITY_EN to add an even-parity bit between the last data bit and the stop bit.
module fifo_uart_tx #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tx_en,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_rd_en,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W  = $clog2(WIDTH + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StData,
`ifdef UART_TX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e             state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic               parity_q, parity_d;
`endif

    logic baud_end;
    assign baud_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        done_d     = 1'b0;
        fifo_rd_en = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            StIdle: begin
                // Gated by rst_n so no read is issued while reset is held.
                fifo_rd_en = rst_n & tx_en & ~fifo_empty;
                tx_d       = 1'b1;
                if (fifo_rd_en) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                shift_d = fifo_dout;
                baud_d  = '0;
                bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                parity_d = ^fifo_dout;
`endif
                tx_d    = 1'b0;
                state_d = StStart;
            end
            StStart: begin
                if (baud_end) begin
                    baud_d  = '0;
                    tx_d    = shift_q[0];
                    state_d = StData;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            StData: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + BIT_W'(1);
                    if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = StParity;
`else
                        tx_d    = 1'b1;
                        state_d = StStop;
`endif
                    end else begin
                        tx_d = shift_d[0];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (baud_end) begin
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    state_d = StStop;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`endif
            StStop: begin
                if (baud_end) begin
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = StIdle;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: behavioural FIFO plus a frame-level expected-waveform model,
// a directed vector table for one frame, and hand-written corner-case sequences.
module tb_fifo_uart_tx;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned C     = 4;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned PAR_EN = 1;
`else
    localparam int unsigned PAR_EN = 0;
`endif
    localparam int unsigned F = WIDTH + 2 + PAR_EN;

    logic             clk;
    logic             rst_n;
    logic             tx_en;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_dout;
    logic             fifo_rd_en;
    logic             tx;
    logic             busy;
    logic             done;

    fifo_uart_tx #(
        .WIDTH       (WIDTH),
        .CLKS_PER_BIT(C)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tx_en     (tx_en),
        .fifo_empty(fifo_empty),
        .fifo_dout (fifo_dout),
        .fifo_rd_en(fifo_rd_en),
        .tx        (tx),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic tx;
        logic busy;
        logic done;
    } exp_t;

    typedef struct {
        int   cyc;
        logic tx;
        logic busy;
        logic done;
        logic rd;
    } vec_t;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] fifo_q[$];
    int               rd_log[$];
    int               done_cnt;
    int               checks;
    int               errors;
    int               cyc;
    logic             rst_r;
    logic             tx_en_r;
    logic             a_tx, a_busy, a_done, a_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Expected line/busy/done for every cycle of a frame whose read was accepted this cycle.
    function automatic void push_frame(input logic [WIDTH-1:0] w);
        logic b;
        exp_q.push_back('{tx: 1'b1, busy: 1'b1, done: 1'b0});
        for (int k = 0; k < int'(F); k++) begin
            if (k == 0) b = 1'b0;
            else if (k <= int'(WIDTH)) b = w[k-1];
            else if (PAR_EN == 1 && k == int'(WIDTH) + 1) b = ^w;
            else b = 1'b1;
            for (int j = 0; j < int'(C); j++) exp_q.push_back('{tx: b, busy: 1'b1, done: 1'b0});
        end
        exp_q.push_back('{tx: 1'b1, busy: 1'b0, done: 1'b1});
    endfunction

    // One clock cycle, entered and left at the falling edge.
    task automatic cycle();
        exp_t e;
        logic exp_rd;
        rst_n      = rst_r;
        tx_en      = tx_en_r;
        fifo_empty = (fifo_q.size() == 0);
        #1;
        a_tx   = tx;
        a_busy = busy;
        a_done = done;
        a_rd   = fifo_rd_en;
        if (!rst_r) begin
            exp_q.delete();
            e      = '{tx: 1'b1, busy: 1'b0, done: 1'b0};
            exp_rd = 1'b0;
        end else begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = '{tx: 1'b1, busy: 1'b0, done: 1'b0};
            exp_rd = (exp_q.size() == 0) && tx_en_r && (fifo_q.size() > 0);
            if (exp_rd) push_frame(fifo_q[0]);
        end
        chk("tx", 32'(a_tx), 32'(e.tx));
        chk("busy", 32'(a_busy), 32'(e.busy));
        chk("done", 32'(a_done), 32'(e.done));
        chk("rd_en", 32'(a_rd), 32'(exp_rd));
        if (a_rd) rd_log.push_back(cyc);
        if (a_done) done_cnt++;
        @(posedge clk);
        #1;
        if (a_rd && fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
        cyc++;
        @(negedge clk);
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || (tx_en_r && fifo_q.size() > 0)) && n < maxc) begin
            cycle();
            n++;
        end
        chk("idle_timeout", 32'(n < maxc), 32'd1);
        repeat (3) cycle();
    endtask

    vec_t tbl[$];
    int   base;
    int   n_rd;
    int   s_cyc;
    int   d_cyc;
    int   cnt;

    initial begin
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        done_cnt   = 0;
        rst_r      = 1'b0;
        tx_en_r    = 1'b1;
        rst_n      = 1'b0;
        tx_en      = 1'b1;
        fifo_dout  = '0;
        fifo_empty = 1'b1;

        // Reset held with data waiting: no read, idle outputs; read in first released cycle.
        fifo_q.push_back(8'h3C);
        @(negedge clk);
        repeat (6) cycle();
        rst_r = 1'b1;
        rd_log.delete();
        cycle();
        chk("first_rd_after_rst", 32'(rd_log.size()), 32'd1);
        wait_idle(200);

        // Directed frame for 0xA5, fifo_empty falls at relative cycle 10.
        tbl.push_back('{9, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{10, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{11, 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{12, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{15, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{16, 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{20, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{24, 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{28, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{32, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{36, 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{40, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{44, 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{47, 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{48, (PAR_EN == 1) ? 1'b0 : 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{51 + 4 * int'(PAR_EN), 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{52 + 4 * int'(PAR_EN), 1'b1, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{53 + 4 * int'(PAR_EN), 1'b1, 1'b0, 1'b0, 1'b0});
        base = cyc;
        for (int i = 0; i < tbl.size(); i++) begin
            while (cyc - base <= tbl[i].cyc) begin
                if (cyc - base == 10) fifo_q.push_back(8'hA5);
                cycle();
            end
            chk("vec_tx", 32'(a_tx), 32'(tbl[i].tx));
            chk("vec_busy", 32'(a_busy), 32'(tbl[i].busy));
            chk("vec_done", 32'(a_done), 32'(tbl[i].done));
            chk("vec_rd", 32'(a_rd), 32'(tbl[i].rd));
        end
        wait_idle(50);

        // Back-to-back words: second read in the done cycle, then nothing more.
        rd_log.delete();
        fifo_q.push_back(8'h00);
        fifo_q.push_back(8'hFF);
        wait_idle(300);
        repeat (20) cycle();
        chk("b2b_reads", 32'(rd_log.size()), 32'd2);
        if (rd_log.size() == 2) chk("b2b_period", 32'(rd_log[1] - rd_log[0]), 32'(F * C + 2));

        // Flow control: tx_en low holds off reads; dropping it mid-frame lets the frame finish.
        rd_log.delete();
        tx_en_r = 1'b0;
        fifo_q.push_back(8'h5A);
        fifo_q.push_back(8'h33);
        cnt = 0;
        repeat (100) begin
            cycle();
            if (!a_tx) cnt++;
        end
        chk("hold_reads", 32'(rd_log.size()), 32'd0);
        chk("hold_tx_low_cycles", 32'(cnt), 32'd0);
        tx_en_r  = 1'b1;
        done_cnt = 0;
        repeat (20) cycle();
        tx_en_r = 1'b0;
        wait_idle(200);
        repeat (10) cycle();
        chk("drop_reads", 32'(rd_log.size()), 32'd1);
        chk("drop_done", 32'(done_cnt), 32'd1);
        chk("drop_left", 32'(fifo_q.size()), 32'd1);
        tx_en_r = 1'b1;
        wait_idle(200);

        // Reset during data bit 3 of 0x00: line goes high without a clock edge.
        rd_log.delete();
        fifo_q.push_back(8'h00);
        fifo_q.push_back(8'h81);
        n_rd = 0;
        while (rd_log.size() == 0 && n_rd < 10) begin
            cycle();
            n_rd++;
        end
        chk("mid_rst_rd_seen", 32'(rd_log.size() > 0), 32'd1);
        if (rd_log.size() > 0) begin
            while (cyc <= rd_log[0] + 19) cycle();
            chk("bit3_low", 32'(a_tx), 32'd0);
            #2;
            rst_n = 1'b0;
            #1;
            chk("async_rst_tx", 32'(tx), 32'd1);
            chk("async_rst_busy", 32'(busy), 32'd0);
            rst_r = 1'b0;
            repeat (3) cycle();
            rst_r = 1'b1;
            wait_idle(200);
            chk("mid_rst_reads", 32'(rd_log.size()), 32'd2);
            chk("mid_rst_fifo", 32'(fifo_q.size()), 32'd0);
        end

        // Start-bit edge to done for 0x07.
        fifo_q.push_back(8'h07);
        s_cyc = -1;
        d_cyc = -1;
        n_rd  = 0;
        while (s_cyc < 0 && n_rd < 20) begin
            cycle();
            if (!a_tx) s_cyc = cyc - 1;
            n_rd++;
        end
        n_rd = 0;
        while (d_cyc < 0 && n_rd < 100) begin
            cycle();
            if (a_done) d_cyc = cyc - 1;
            n_rd++;
        end
        chk("edge_found", 32'(s_cyc >= 0 && d_cyc >= 0), 32'd1);
        chk("start_to_done", 32'(d_cyc - s_cyc), 32'(F * C));
        wait_idle(100);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0 && fifo_q.size() < 4)
                fifo_q.push_back(WIDTH'($urandom));
            tx_en_r = ($urandom_range(0, 3) != 0);
            cycle();
        end
        tx_en_r = 1'b1;
        wait_idle(2000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
